jtdsp16_rom_arb: RTL
====================

JTDSP16_ROM_ARB -- requirements
Module: jtdsp16_rom_arb

Interface
REQ-001 Parameter EXT_WAIT, default 1: extra cen cycles added to each external-bus access when ext_mode=1 (range 0-3).
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cen  in  1  DSP clock enable (cen2 rate); all state advances only on clk edges with cen=1.
REQ-005 ext_mode  in  1  EXM pin; 1 routes all reads to external bus ab/rb_din.
REQ-006 hold  in  1  CPU halted; enables programming port, blocks CPU requesters.
REQ-007 fetch_req  in  1  instruction fetch request; fetch_addr  in  16  fetch address.
REQ-008 data_req  in  1  table/X-space data read request; data_addr  in  16  data address.
REQ-009 prog_req  in  1  ROM byte write request; prog_addr  in  13  byte address; prog_data  in  8  byte.
REQ-010 rom_dout  in  16  internal ROM read data, valid one cen cycle after rom_addr.
REQ-011 rb_din  in  16  external ROM data bus.
REQ-012 rom_addr  out  16  internal ROM read address (registered).
REQ-013 ab  out  16  external address bus (registered).
REQ-014 rom_we  out  1  byte write strobe; rom_waddr  out  13; rom_wdata  out  8.
REQ-015 fetch_ack / data_ack / prog_ack  out  1 each  completion strobes, high for exactly one cen period.
REQ-016 rd_data  out  16  read result, valid while fetch_ack or data_ack is high.
REQ-017 pc_halt  out  1  combinational: fetch_req=1 and fetch not granted this cen cycle, or fetch access in progress without ack.

Function
REQ-018 States: IDLE, RD_INT, RD_EXT, WAIT, WR; state register and owner register (FETCH/DATA/PROG) update only when cen=1.
REQ-019 Arbitration in IDLE or in the cycle an access completes: prog (only if hold=1) > data > fetch; fetch and data never granted while hold=1.
REQ-020 Anti-starvation: 2-bit counter of consecutive data grants while fetch_req=1; at count 2 fetch wins next arbitration; counter clears on any fetch grant or when fetch_req=0.
REQ-021 Internal read (ext_mode=0): grant cycle registers rom_addr=granted address, state RD_INT; next cen cycle rd_data=rom_dout and owner ack asserted; back-to-back grants allowed in that same cycle (one access per cen cycle throughput).
REQ-022 External read (ext_mode=1): grant registers ab, state RD_EXT, then EXT_WAIT cen cycles in WAIT; rb_din sampled in the final cycle, ack asserted the following cen cycle; rom_addr unchanged.
REQ-023 ext_mode sampled at grant; changes mid-access affect only the next grant.
REQ-024 Write: prog grant drives rom_we=1, rom_waddr, rom_wdata for one cen period (state WR); prog_ack asserted the following cen period; writes always target internal array regardless of ext_mode.
REQ-025 Simultaneous requests: losers wait with request held; dropping a request before grant cancels it with no ack.
REQ-026 Requesters SHALL hold address stable until ack; arbiter registers address at grant and ignores later changes.
REQ-027 hold rising mid CPU access: access completes and acks; subsequent CPU grants blocked.
REQ-028 No request pending: state IDLE, rom_addr/ab retain last value, all acks 0.

Reset
REQ-029 rst=1 (at clk edge, independent of cen): state IDLE, owner FETCH, counter 0, rom_addr=0, ab=0, rd_data=0, rom_we=0, all acks 0; in-flight access aborted with no ack.
REQ-030 First cen cycle after rst release performs normal arbitration.

Verification
REQ-031 ext_mode=0, fetch_req with fetch_addr=0x0123 -> rom_addr=0x0123 next cen; following cen fetch_ack=1, rd_data=rom_dout; pc_halt=0 throughout.
REQ-032 data_req and fetch_req held continuously -> grant sequence data, data, fetch, data, data, fetch; pc_halt=1 in data-grant cycles.
REQ-033 ext_mode=1, EXT_WAIT=2, data_addr=0x8000 -> ab=0x8000, data_ack 4 cen cycles after grant with rd_data=rb_din value in last wait cycle.
REQ-034 hold=1, prog_req addr=0x1ABC data=0x5A with fetch_req=1 -> rom_we one cen period with rom_waddr=0x1ABC, rom_wdata=0x5A, prog_ack next; no fetch grant; pc_halt=1.
REQ-035 rst asserted during WAIT of external read -> next cycle state IDLE, ab=0, no data_ack ever issued for that request.

Source files
------------

// File: rtl/jtdsp16_rom_arb.sv
// jtdsp16_rom_arb: shares the program ROM among instruction fetch, data reads
// and the byte-wide programming port, with an optional slow external bus.
module jtdsp16_rom_arb #(
    parameter int EXT_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        ext_mode,
    input  logic        hold,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        data_req,
    input  logic [15:0] data_addr,
    input  logic        prog_req,
    input  logic [12:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [15:0] rom_dout,
    input  logic [15:0] rb_din,
    output logic [15:0] rom_addr,
    output logic [15:0] ab,
    output logic        rom_we,
    output logic [12:0] rom_waddr,
    output logic [7:0]  rom_wdata,
    output logic        fetch_ack,
    output logic        data_ack,
    output logic        prog_ack,
    output logic [15:0] rd_data,
    output logic        pc_halt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_INT,
        S_RD_EXT,
        S_WAIT,
        S_WR
    } state_t;

    typedef enum logic [1:0] {
        OWN_FETCH,
        OWN_DATA,
        OWN_PROG
    } owner_t;

    // Index of the last wait cycle; the external data is sampled there.
    localparam logic [1:0] WLAST = (EXT_WAIT == 0) ? 2'd0 : 2'(EXT_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;
    logic [1:0] wcnt;
    logic [1:0] starve;
    logic       done;
    logic       arb_ok;
    logic       cpu_ok;
    logic       fetch_pri;
    logic       g_prog;
    logic       g_data;
    logic       g_fetch;

    // Completion detect, arbitration, next state and the PC stall signal.
    always_comb begin
        done      = 1'b0;
        state_nxt = state;
        unique case (state)
            S_RD_INT: done = 1'b1;
            S_WR:     done = 1'b1;
            S_RD_EXT: done = (EXT_WAIT == 0);
            S_WAIT:   done = (wcnt == WLAST);
            default:  done = 1'b0;
        endcase

        arb_ok    = (state == S_IDLE) || done;
        fetch_pri = (starve == 2'd2);
        g_prog    = arb_ok && hold && prog_req;
        cpu_ok    = arb_ok && !hold;
        g_data    = cpu_ok && data_req && !(fetch_req && fetch_pri);
        g_fetch   = cpu_ok && fetch_req && !g_data;

        if (done) begin
            state_nxt = S_IDLE;
        end else if (state == S_RD_EXT) begin
            state_nxt = S_WAIT;
        end

        if (g_prog) begin
            state_nxt = S_WR;
        end else if (g_data || g_fetch) begin
            state_nxt = ext_mode ? S_RD_EXT : S_RD_INT;
        end

        // An internal read always finishes at the next cen edge, so only the
        // multi-cycle external access stalls the PC once granted.
        pc_halt = (fetch_req && !g_fetch) ||
                  ((owner == OWN_FETCH) &&
                   ((state == S_RD_EXT) || (state == S_WAIT)));
    end

    // State, owner, buses and completion strobes advance on cen edges only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= OWN_FETCH;
            wcnt      <= 2'd0;
            starve    <= 2'd0;
            rom_addr  <= 16'd0;
            ab        <= 16'd0;
            rom_we    <= 1'b0;
            rom_waddr <= 13'd0;
            rom_wdata <= 8'd0;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            prog_ack  <= 1'b0;
            rd_data   <= 16'd0;
        end else if (cen) begin
            state     <= state_nxt;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            prog_ack  <= 1'b0;
            rom_we    <= g_prog;

            if (state == S_RD_EXT) begin
                wcnt <= 2'd0;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt + 2'd1;
            end

            if (done) begin
                unique case (owner)
                    OWN_FETCH: fetch_ack <= 1'b1;
                    OWN_DATA:  data_ack  <= 1'b1;
                    default:   prog_ack  <= 1'b1;
                endcase
                if (owner != OWN_PROG) begin
                    rd_data <= (state == S_RD_INT) ? rom_dout : rb_din;
                end
            end

            if (!fetch_req || g_fetch) begin
                starve <= 2'd0;
            end else if (g_data && (starve != 2'd2)) begin
                starve <= starve + 2'd1;
            end

            if (g_prog) begin
                owner     <= OWN_PROG;
                rom_waddr <= prog_addr;
                rom_wdata <= prog_data;
            end else if (g_data) begin
                owner <= OWN_DATA;
                if (ext_mode) ab <= data_addr;
                else rom_addr <= data_addr;
            end else if (g_fetch) begin
                owner <= OWN_FETCH;
                if (ext_mode) ab <= fetch_addr;
                else rom_addr <= fetch_addr;
            end
        end
    end

endmodule
